// File: rtl/mux_scan_n.sv
// mux_scan_n: N-channel W-bit registered mux with manual select and auto-scan dwell sequencing.
// Optional SCAN_MASK_EN adds chan_mask so that scan skips channels whose mask bit is 0.
module mux_scan_n #(
  parameter int N = 7,
  parameter int W = 1,
  parameter int DWELL = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic [N*W-1:0]  data_in,
  input  logic [SELW-1:0] sel,
  input  logic            mode,
  input  logic            enable,
`ifdef SCAN_MASK_EN
  input  logic [N-1:0]    chan_mask,
`endif
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_chan,
  output logic            out_valid,
  output logic            wrap
);
  localparam int DW = DWELL > 1 ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] LAST_DW = DW'(DWELL - 1);
  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;
  state_t state;
  logic [DW-1:0] dwell_cnt;
  logic [N-1:0] mask;
  logic [W-1:0] chans [N];
  logic [SELW-1:0] man_ch, nxt_ch, first_ch, start_ch, k;
`ifdef SCAN_MASK_EN
  assign mask = chan_mask;
`else
  assign mask = '1;
`endif
  assign man_ch = (int'(sel) >= N) ? SELW'(N - 1) : sel;
  assign start_ch = (state == IDLE) ? first_ch : out_chan;
  // Descending search so the nearest enabled channel wins.
  always_comb begin
    nxt_ch = out_chan;
    first_ch = '0;
    k = '0;
    for (int i = N; i >= 1; i--) begin
      k = SELW'((int'(out_chan) + i) % N);
      if (mask[k]) nxt_ch = k;
    end
    for (int i = N - 1; i >= 0; i--)
      if (mask[i]) first_ch = SELW'(i);
    for (int i = 0; i < N; i++) chans[i] = data_in[i*W +: W];
  end
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      dwell_cnt <= '0;
      out_data <= '0;
      out_chan <= '0;
      out_valid <= 1'b0;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      dwell_cnt <= '0;
      if (!enable) begin
        state <= IDLE;
        out_valid <= 1'b0;
      end else if (!mode) begin
        state <= MANUAL;
        out_chan <= man_ch;
        out_data <= mask[man_ch] ? chans[man_ch] : '0;
        out_valid <= mask[man_ch];
      end else if (state != SCAN) begin
        state <= SCAN;
        out_chan <= start_ch;
        out_data <= chans[start_ch];
        out_valid <= |mask;
      end else if (~|mask) begin
        out_data <= chans[out_chan];
        out_valid <= 1'b0;
      end else if (dwell_cnt == LAST_DW) begin
        out_chan <= nxt_ch;
        out_data <= chans[nxt_ch];
        out_valid <= 1'b1;
        wrap <= nxt_ch <= out_chan;
      end else begin
        dwell_cnt <= dwell_cnt + DW'(1);
        out_data <= chans[out_chan];
        out_valid <= 1'b1;
      end
    end
endmodule

// File: tb/tb_mux_scan_n.sv
// tb_mux_scan_n: directed checks of mux_scan_n with N=7, W=4, DWELL=3, channel k carrying k+1.
module tb_mux_scan_n;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic [27:0] data_in = {4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
  logic [2:0] sel = '0;
  logic mode = 1'b0;
  logic enable = 1'b0;
  logic [3:0] out_data;
  logic [2:0] out_chan;
  logic out_valid, wrap;
  logic [8:0] got, exp;
  int vecs = 0;
  int errs = 0;
`ifdef SCAN_MASK_EN
  logic [6:0] chan_mask = '1;
`endif
  mux_scan_n #(.N(7), .W(4), .DWELL(3)) dut (
    .clock(clock), .resetn(resetn), .data_in(data_in), .sel(sel), .mode(mode), .enable(enable),
`ifdef SCAN_MASK_EN
    .chan_mask(chan_mask),
`endif
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid), .wrap(wrap)
  );
  always #5 clock = ~clock;
  assign got = {out_valid, out_chan, out_data, wrap};
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic go_idle;
    enable = 1'b0;
    tick();
  endtask
  task automatic test_reset;
    tick();
    tick();
    vecs++;
    if (got !== 9'h0) begin errs++; $display("FAIL reset_state got %h want %h", got, 9'h0); end
    #2 resetn = 1'b1;
  endtask
  task automatic test_manual;
    go_idle();
    enable = 1'b1; mode = 1'b0;
    sel = 3'd5; tick(); exp = {1'b1, 3'd5, 4'd6, 1'b0}; vecs++;
    if (got !== exp) begin errs++; $display("FAIL manual_sel5 got %h want %h", got, exp); end
    sel = 3'd7; tick(); exp = {1'b1, 3'd6, 4'd7, 1'b0}; vecs++;
    if (got !== exp) begin errs++; $display("FAIL manual_clamp got %h want %h", got, exp); end
    sel = 3'd0; tick(); exp = {1'b1, 3'd0, 4'd1, 1'b0}; vecs++;
    if (got !== exp) begin errs++; $display("FAIL manual_sel0 got %h want %h", got, exp); end
    sel = 3'd6; tick(); exp = {1'b1, 3'd6, 4'd7, 1'b0}; vecs++;
    if (got !== exp) begin errs++; $display("FAIL manual_sel6 got %h want %h", got, exp); end
  endtask
  task automatic test_scan;
    go_idle();
    enable = 1'b1; mode = 1'b1;
    for (int c = 0; c < 24; c++) begin
      tick();
      exp = {1'b1, 3'((c / 3) % 7), 4'((c / 3) % 7 + 1), c == 21};
      vecs++;
      if (got !== exp) begin errs++; $display("FAIL scan_step%0d got %h want %h", c, got, exp); end
    end
  endtask
  task automatic test_mode_switch;
    go_idle();
    enable = 1'b1; mode = 1'b1;
    repeat (10) tick();
    mode = 1'b0; sel = 3'd1; tick();
    exp = {1'b1, 3'd1, 4'd2, 1'b0}; vecs++;
    if (got !== exp) begin errs++; $display("FAIL mode_to_manual got %h want %h", got, exp); end
    mode = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      exp = (c < 3) ? {1'b1, 3'd1, 4'd2, 1'b0} : {1'b1, 3'd2, 4'd3, 1'b0};
      vecs++;
      if (got !== exp) begin errs++; $display("FAIL mode_to_scan%0d got %h want %h", c, got, exp); end
    end
    tick(); tick();
    mode = 1'b0; sel = 3'd4; tick();
    exp = {1'b1, 3'd4, 4'd5, 1'b0}; vecs++;
    if (got !== exp) begin errs++; $display("FAIL mode_vs_expiry got %h want %h", got, exp); end
    mode = 1'b1;
    repeat (9) tick();
    mode = 1'b0; sel = 3'd6; tick();
    exp = {1'b1, 3'd6, 4'd7, 1'b0}; vecs++;
    if (got !== exp) begin errs++; $display("FAIL mode_vs_wrap got %h want %h", got, exp); end
  endtask
  task automatic test_enable_drop;
    go_idle();
    enable = 1'b1; mode = 1'b1;
    repeat (7) tick();
    enable = 1'b0; tick();
    exp = {1'b0, 3'd2, 4'd3, 1'b0}; vecs++;
    if (got !== exp) begin errs++; $display("FAIL enable_drop got %h want %h", got, exp); end
    enable = 1'b1; tick();
    exp = {1'b1, 3'd0, 4'd1, 1'b0}; vecs++;
    if (got !== exp) begin errs++; $display("FAIL enable_restart got %h want %h", got, exp); end
  endtask
  task automatic test_live_data;
    go_idle();
    enable = 1'b1; mode = 1'b1; tick();
    data_in[3:0] = 4'hA; tick();
    exp = {1'b1, 3'd0, 4'hA, 1'b0}; vecs++;
    if (got !== exp) begin errs++; $display("FAIL live_scan got %h want %h", got, exp); end
    mode = 1'b0; sel = 3'd3; data_in[15:12] = 4'h9; tick();
    exp = {1'b1, 3'd3, 4'h9, 1'b0}; vecs++;
    if (got !== exp) begin errs++; $display("FAIL live_manual got %h want %h", got, exp); end
    data_in = {4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
  endtask
  task automatic test_async_reset;
    go_idle();
    enable = 1'b1; mode = 1'b1;
    repeat (5) tick();
    resetn = 1'b0;
    #2; vecs++;
    if (got !== 9'h0) begin errs++; $display("FAIL async_reset got %h want %h", got, 9'h0); end
    #2 resetn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      exp = (c < 3) ? {1'b1, 3'd0, 4'd1, 1'b0} : {1'b1, 3'd1, 4'd2, 1'b0};
      vecs++;
      if (got !== exp) begin errs++; $display("FAIL reset_restart%0d got %h want %h", c, got, exp); end
    end
  endtask
`ifdef SCAN_MASK_EN
  task automatic test_mask;
    logic [2:0] seq [4] = '{3'd0, 3'd2, 3'd5, 3'd0};
    go_idle();
    chan_mask = 7'b0100101;
    enable = 1'b1; mode = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      exp = {1'b1, seq[c / 3], 4'(seq[c / 3] + 1), c == 9};
      vecs++;
      if (got !== exp) begin errs++; $display("FAIL mask_step%0d got %h want %h", c, got, exp); end
    end
    chan_mask = '0; tick();
    exp = {1'b0, 3'd0, 4'd1, 1'b0}; vecs++;
    if (got !== exp) begin errs++; $display("FAIL mask_zero got %h want %h", got, exp); end
    chan_mask = '1;
  endtask
`endif
  initial begin
    test_reset();
    test_manual();
    test_scan();
    test_mode_switch();
    test_enable_drop();
    test_live_data();
    test_async_reset();
`ifdef SCAN_MASK_EN
    test_mask();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
